// File: rtl/cpu_pkg.sv
// Shared definitions for the boot loader: loader state encoding, status codes,
// bus widths and the default load address.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] LOAD_BASE_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    ST_HDR_HI,
    ST_HDR_LO,
    ST_WORD,
    ST_WRITE,
    ST_RUN
  } state_t;

  localparam logic [7:0] STATUS_HDR_HI = 8'hB0;
  localparam logic [7:0] STATUS_HDR_LO = 8'hB1;
  localparam logic [7:0] STATUS_WORD   = 8'hB2;
  localparam logic [7:0] STATUS_WRITE  = 8'hB3;
  localparam logic [7:0] STATUS_RUN    = 8'h00;

  function automatic logic [7:0] status_of(input state_t s);
    case (s)
      ST_HDR_HI: return STATUS_HDR_HI;
      ST_HDR_LO: return STATUS_HDR_LO;
      ST_WORD:   return STATUS_WORD;
      ST_WRITE:  return STATUS_WRITE;
      default:   return STATUS_RUN;
    endcase
  endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Collects image bytes MSB-first into a 32-bit word; word_valid strobes on
// the byte that completes the word, with word already showing that byte.
module byte_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [23:0] shift;
  logic [1:0]  byte_cnt;

  assign word       = {shift, byte_in};
  assign word_valid = byte_valid && (byte_cnt == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift    <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      shift    <= word[23:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed program image from the byte link into RAM while
// holding the CPU in reset, then hands the RAM port over to the CPU.
module boot_loader
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LOAD_BASE = LOAD_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [WORD_W-1:0] cpu_data,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_wren,
  output logic              cpu_nreset,
  output logic [WORD_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [7:0]        status
);

  state_t              state;
  logic [ADDR_W-1:0]   count;
  logic [ADDR_W-1:0]   index;
  logic                ram_wren_q;
  logic [ADDR_W-1:0]   ram_address_q;
  logic [WORD_W-1:0]   ram_data_q;

  logic                accept;
  logic                pack_valid;
  logic [WORD_W-1:0]   pack_word;
  logic                pack_word_valid;

  assign rx_ready   = (state == ST_HDR_HI) || (state == ST_HDR_LO) || (state == ST_WORD);
  assign accept     = rx_valid && rx_ready;
  assign pack_valid = accept && (state == ST_WORD);
  assign status     = status_of(state);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == ST_WRITE),
    .byte_valid (pack_valid),
    .byte_in    (rx_data),
    .word       (pack_word),
    .word_valid (pack_word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_HDR_HI;
      count         <= '0;
      index         <= '0;
      cpu_nreset    <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_address_q <= LOAD_BASE;
      ram_data_q    <= '0;
    end else begin
      ram_wren_q <= 1'b0;
      case (state)
        ST_HDR_HI: begin
          if (accept) begin
            count[15:8] <= rx_data;
            state       <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (accept) begin
            count[7:0] <= rx_data;
            index      <= '0;
            if ({count[15:8], rx_data} == 16'd0) begin
              state      <= ST_RUN;
              cpu_nreset <= 1'b1;
            end else begin
              state <= ST_WORD;
            end
          end
        end
        ST_WORD: begin
          if (pack_word_valid) begin
            state         <= ST_WRITE;
            ram_wren_q    <= 1'b1;
            ram_address_q <= LOAD_BASE + index;
            ram_data_q    <= pack_word;
          end
        end
        ST_WRITE: begin
          // Compare against N-1 so a full 65535-word image never overflows index.
          if (index == count - 16'd1) begin
            state      <= ST_RUN;
            cpu_nreset <= 1'b1;
          end else begin
            index <= index + 16'd1;
            state <= ST_WORD;
          end
        end
        ST_RUN: begin
        end
        default: state <= ST_HDR_HI;
      endcase
    end
  end

  // The CPU owns the RAM port only once loading is finished.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    ram_wren    = ram_wren_q;
    ram_address = ram_address_q;
    ram_data    = ram_data_q;
    if (state == ST_RUN) begin
      ram_wren    = cpu_wren;
      ram_address = cpu_address;
      ram_data    = cpu_data;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: two instances (base 0000 and FFFF) share
// one byte stream; loader writes are logged and compared with an image model.
module tb_boot_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] cpu_data;
  logic [15:0] cpu_address;
  logic        cpu_wren;

  logic        rx_ready_0, cpu_nreset_0, ram_wren_0;
  logic [31:0] ram_data_0;
  logic [15:0] ram_address_0;
  logic [7:0]  status_0;

  logic        rx_ready_1, cpu_nreset_1, ram_wren_1;
  logic [31:0] ram_data_1;
  logic [15:0] ram_address_1;
  logic [7:0]  status_1;

  boot_loader #(.LOAD_BASE(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_0), .cpu_data(cpu_data), .cpu_address(cpu_address),
    .cpu_wren(cpu_wren), .cpu_nreset(cpu_nreset_0), .ram_data(ram_data_0),
    .ram_address(ram_address_0), .ram_wren(ram_wren_0), .status(status_0)
  );

  boot_loader #(.LOAD_BASE(16'hFFFF)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready_1), .cpu_data(cpu_data), .cpu_address(cpu_address),
    .cpu_wren(cpu_wren), .cpu_nreset(cpu_nreset_1), .ram_data(ram_data_1),
    .ram_address(ram_address_1), .ram_wren(ram_wren_1), .status(status_1)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        nrst;
    int          cyc;
  } wr_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wr_t        log0[$];
  wr_t        log1[$];
  int         acc_q[$];
  logic [7:0] payload[$];
  int         rise0, rise1, rdy_low, rdy_low_cyc;
  logic       prev_nrst0, prev_nrst1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, half a period away from state changes.
  always @(negedge clk) begin
    if (ram_wren_0 && status_0 != 8'h00)
      log0.push_back(wr_t'{ram_address_0, ram_data_0, cpu_nreset_0, cyc});
    if (ram_wren_1 && status_1 != 8'h00)
      log1.push_back(wr_t'{ram_address_1, ram_data_1, cpu_nreset_1, cyc});
    if (cpu_nreset_0 === 1'b1 && prev_nrst0 === 1'b0) rise0 = cyc;
    if (cpu_nreset_1 === 1'b1 && prev_nrst1 === 1'b0) rise1 = cyc;
    prev_nrst0 = cpu_nreset_0;
    prev_nrst1 = cpu_nreset_1;
    if (rx_ready_0 === 1'b0 && cpu_nreset_0 === 1'b0) begin
      rdy_low++;
      rdy_low_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: word i of the image is its four payload bytes, MSB first,
  // stored at base+i modulo 2^16.
  function automatic logic [31:0] model_word(input int i);
    return {payload[4*i], payload[4*i+1], payload[4*i+2], payload[4*i+3]};
  endfunction

  function automatic logic [15:0] model_addr(input logic [15:0] base, input int i);
    logic [15:0] off;
    off = i[15:0];
    return base + off;
  endfunction

  task automatic clear_mon();
    log0.delete();
    log1.delete();
    acc_q.delete();
    rise0       = -1;
    rise1       = -1;
    rdy_low     = 0;
    rdy_low_cyc = -1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    cpu_wren = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rx_ready_0 === 1'b1) begin
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_byte: byte %02h not accepted within 200 cycles", b);
    end
  endtask

  // Header then payload; gap<0 picks a random 0..3 idle gap between payload bytes.
  task automatic send_image(input logic [15:0] n, input int gap);
    int g;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < payload.size(); i++) begin
      send_byte(payload[i]);
      if (i != payload.size() - 1) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        if (g > 0) idle(g);
      end
    end
    idle(4);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (status_0 !== 8'hB0) begin bad++; $display("FAIL reset_status: got %h want b0", status_0); end
    total++; if (rx_ready_0 !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready_0); end
    total++; if (cpu_nreset_0 !== 1'b0) begin bad++; $display("FAIL reset_cpu_nreset: got %b want 0", cpu_nreset_0); end
    total++; if (ram_wren_0 !== 1'b0) begin bad++; $display("FAIL reset_ram_wren: got %b want 0", ram_wren_0); end
    total++; if (ram_data_0 !== 32'h0) begin bad++; $display("FAIL reset_ram_data: got %h want 0", ram_data_0); end
    total++; if (ram_address_0 !== 16'h0000) begin bad++; $display("FAIL reset_addr0: got %h want 0000", ram_address_0); end
    total++; if (ram_address_1 !== 16'hFFFF) begin bad++; $display("FAIL reset_addr1: got %h want ffff", ram_address_1); end
  endtask

  task automatic test_two_words();
    logic [15:0] a1;
    do_reset();
    payload = '{8'h01, 8'h00, 8'h00, 8'h05, 8'h0A, 8'h01, 8'h02, 8'h03};
    send_image(16'd2, 0);
    total++; if (log0.size() != 2) begin bad++; $display("FAIL two_count: got %0d writes want 2", log0.size()); end
    if (log0.size() == 2) begin
      total++; if (log0[0].addr !== 16'h0000 || log0[0].data !== 32'h01000005)
        begin bad++; $display("FAIL two_w0: got %h/%h want 0000/01000005", log0[0].addr, log0[0].data); end
      total++; if (log0[1].addr !== 16'h0001 || log0[1].data !== 32'h0A010203)
        begin bad++; $display("FAIL two_w1: got %h/%h want 0001/0a010203", log0[1].addr, log0[1].data); end
      total++; if (log0[0].nrst !== 1'b0 || log0[1].nrst !== 1'b0)
        begin bad++; $display("FAIL two_cpu_held: nreset during writes %b %b want 0 0", log0[0].nrst, log0[1].nrst); end
      total++; if (log0[0].cyc != acc_q[5]) begin bad++; $display("FAIL two_latency: write at %0d want %0d", log0[0].cyc, acc_q[5]); end
      total++; if (rise0 != log0[1].cyc + 1) begin bad++; $display("FAIL two_nreset_rise: at %0d want %0d", rise0, log0[1].cyc + 1); end
    end
    total++; if (acc_q.size() != 10 || acc_q[6] != acc_q[5] + 2)
      begin bad++; $display("FAIL two_next_accept: %0d bytes taken, 5th payload gap wrong", acc_q.size()); end
    total++; if (status_0 !== 8'h00) begin bad++; $display("FAIL two_status: got %h want 00", status_0); end
    total++; if (rx_ready_0 !== 1'b0) begin bad++; $display("FAIL two_rx_ready: got %b want 0", rx_ready_0); end
    total++; if (log1.size() != 2) begin bad++; $display("FAIL wrap_count: got %0d writes want 2", log1.size()); end
    for (int i = 0; i < 2 && i < log1.size(); i++) begin
      a1 = model_addr(16'hFFFF, i);
      total++; if (log1[i].addr !== a1 || log1[i].data !== model_word(i))
        begin bad++; $display("FAIL wrap_w%0d: got %h/%h want %h/%h", i, log1[i].addr, log1[i].data, a1, model_word(i)); end
    end
  endtask

  task automatic test_zero();
    do_reset();
    payload.delete();
    send_image(16'd0, 0);
    total++; if (log0.size() != 0 || log1.size() != 0) begin bad++; $display("FAIL zero_writes: got %0d/%0d want 0", log0.size(), log1.size()); end
    total++; if (rise0 != acc_q[1]) begin bad++; $display("FAIL zero_nreset_rise: at %0d want %0d", rise0, acc_q[1]); end
    total++; if (cpu_nreset_0 !== 1'b1) begin bad++; $display("FAIL zero_nreset: got %b want 1", cpu_nreset_0); end
    total++; if (rx_ready_0 !== 1'b0) begin bad++; $display("FAIL zero_rx_ready: got %b want 0", rx_ready_0); end
    total++; if (status_0 !== 8'h00) begin bad++; $display("FAIL zero_status: got %h want 00", status_0); end
  endtask

  task automatic test_gaps();
    do_reset();
    payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_image(16'd1, 3);
    total++; if (log0.size() != 1) begin bad++; $display("FAIL gaps_count: got %0d writes want 1", log0.size()); end
    if (log0.size() == 1) begin
      total++; if (log0[0].addr !== 16'h0000 || log0[0].data !== 32'hDEADBEEF)
        begin bad++; $display("FAIL gaps_word: got %h/%h want 0000/deadbeef", log0[0].addr, log0[0].data); end
      total++; if (rdy_low != 1 || rdy_low_cyc != log0[0].cyc)
        begin bad++; $display("FAIL gaps_rx_ready: low %0d cycles at %0d want 1 at %0d", rdy_low, rdy_low_cyc, log0[0].cyc); end
    end
  endtask

  task automatic test_passthrough();
    int          n;
    logic [31:0] d;
    logic [15:0] a;
    logic        w;
    do_reset();
    n = $urandom_range(1, 3);
    payload.delete();
    for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
    cpu_wren    = 1'b1;
    cpu_address = 16'h0005;
    cpu_data    = $urandom;
    send_image(16'(n), -1);
    total++; if (log0.size() != n) begin bad++; $display("FAIL pt_count: got %0d writes want %0d", log0.size(), n); end
    for (int i = 0; i < n && i < log0.size(); i++) begin
      total++; if (log0[i].addr !== model_addr(16'h0000, i) || log0[i].data !== model_word(i))
        begin bad++; $display("FAIL pt_w%0d: got %h/%h want %h/%h", i, log0[i].addr, log0[i].data, model_addr(16'h0000, i), model_word(i)); end
    end
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 16'h0005 : 16'($urandom);
      d = (k == 0) ? 32'h12345678 : $urandom;
      w = (k == 0) ? 1'b1 : 1'($urandom);
      cpu_address = a;
      cpu_data    = d;
      cpu_wren    = w;
      #1;
      total++; if (ram_address_0 !== a || ram_data_0 !== d || ram_wren_0 !== w)
        begin bad++; $display("FAIL pt_run%0d: got %h/%h/%b want %h/%h/%b", k, ram_address_0, ram_data_0, ram_wren_0, a, d, w); end
    end
    cpu_wren = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_image(16'd1, 0);
    total++; if (log0.size() != 1) begin bad++; $display("FAIL mid_count: got %0d writes want 1", log0.size()); end
    if (log0.size() == 1) begin
      total++; if (log0[0].addr !== 16'h0000 || log0[0].data !== 32'h11223344)
        begin bad++; $display("FAIL mid_word: got %h/%h want 0000/11223344", log0[0].addr, log0[0].data); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      n = $urandom_range(1, 5);
      payload.delete();
      for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
      send_image(16'(n), -1);
      total++; if (log0.size() != n || log1.size() != n)
        begin bad++; $display("FAIL rand%0d_count: got %0d/%0d writes want %0d", it, log0.size(), log1.size(), n); end
      for (int i = 0; i < n && i < log0.size() && i < log1.size(); i++) begin
        total++; if (log0[i].addr !== model_addr(16'h0000, i) || log0[i].data !== model_word(i) ||
                     log1[i].addr !== model_addr(16'hFFFF, i) || log1[i].data !== model_word(i))
          begin bad++; $display("FAIL rand%0d_w%0d: got %h/%h %h/%h want data %h", it, i, log0[i].addr, log0[i].data, log1[i].addr, log1[i].data, model_word(i)); end
      end
      if (log0.size() == n) begin
        total++; if (rise0 != log0[n-1].cyc + 1 || rise1 != rise0)
          begin bad++; $display("FAIL rand%0d_nreset: rise %0d/%0d want %0d", it, rise0, rise1, log0[n-1].cyc + 1); end
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    cpu_data    = 32'h0;
    cpu_address = 16'h0;
    cpu_wren    = 1'b0;
    prev_nrst0  = 1'b0;
    prev_nrst1  = 1'b0;
    clear_mon();
    test_reset();
    test_two_words();
    test_reset();
    test_zero();
    test_gaps();
    test_passthrough();
    test_reset_mid();
    test_random();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
